// File: rtl/restoring_divider_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and default operand width.
package restoring_divider_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/restoring_divider_sub_cout.sv
// Trial subtractor: A - B computed as A + ~B + 1; COUT=1 means A >= B (no borrow).
module sub_cout #(
  parameter int W = 5
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] O,
  output logic         COUT
);

  logic [W:0] sum;

  assign sum       = {1'b0, A} + {1'b0, ~B} + (W+1)'(1);
  assign O         = sum[W-1:0];
  assign COUT      = sum[W];

endmodule

// File: rtl/restoring_divider.sv
// Sequential restoring divider: one quotient bit per BUSY cycle, valid/ready on both sides.
module restoring_divider
  import restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             ASYNCRESET,
  input  logic             I_VALID,
  output logic             I_READY,
  input  logic [WIDTH-1:0] DIVIDEND,
  input  logic [WIDTH-1:0] DIVISOR,
  output logic             O_VALID,
  input  logic             O_READY,
  output logic [WIDTH-1:0] QUOTIENT,
  output logic [WIDTH-1:0] REMAINDER,
  output logic             DIV_BY_ZERO
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic [WIDTH-1:0] quo_reg, quo_next;
  logic [WIDTH-1:0] dsr_reg, dsr_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             dbz_reg, dbz_next;

  logic [WIDTH:0]   trial_a;
  logic [WIDTH:0]   trial_diff;
  logic             trial_cout;
  logic             no_borrow;

  // quo_reg doubles as the dividend shift register; its MSB feeds the remainder each step
  assign trial_a = {rem_reg, quo_reg[WIDTH-1]};

  sub_cout #(
    .W (WIDTH + 1)
  ) u_sub (
    .A    (trial_a),
    .B    ({1'b0, dsr_reg}),
    .O    (trial_diff),
    .COUT (trial_cout)
  );

  // A successful difference always fits in WIDTH bits, so its top bit is zero whenever COUT=1
  assign no_borrow = trial_cout & ~trial_diff[WIDTH];

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state_reg <= IDLE;
      rem_reg   <= '0;
      quo_reg   <= '0;
      dsr_reg   <= '0;
      cnt_reg   <= '0;
      dbz_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
      quo_reg   <= quo_next;
      dsr_reg   <= dsr_next;
      cnt_reg   <= cnt_next;
      dbz_reg   <= dbz_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    quo_next   = quo_reg;
    dsr_next   = dsr_reg;
    cnt_next   = cnt_reg;
    dbz_next   = dbz_reg;
    case (state_reg)
      IDLE: begin
        if (I_VALID) begin
          quo_next   = DIVIDEND;
          dsr_next   = DIVISOR;
          rem_next   = '0;
          cnt_next   = '0;
          dbz_next   = (DIVISOR == '0);
          state_next = BUSY;
        end
      end
      BUSY: begin
        rem_next = no_borrow ? trial_diff[WIDTH-1:0] : trial_a[WIDTH-1:0];
        quo_next = {quo_reg[WIDTH-2:0], no_borrow};
        if (cnt_reg == LAST) begin
          cnt_next   = '0;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      DONE: begin
        if (O_READY) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign I_READY     = (state_reg == IDLE);
  assign O_VALID     = (state_reg == DONE);
  assign QUOTIENT    = quo_reg;
  assign REMAINDER   = rem_reg;
  assign DIV_BY_ZERO = dbz_reg;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed self-checking bench for restoring_divider at WIDTH=4.
module tb_restoring_divider;

  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         ASYNCRESET;
  logic         I_VALID;
  logic         I_READY;
  logic [W-1:0] DIVIDEND;
  logic [W-1:0] DIVISOR;
  logic         O_VALID;
  logic         O_READY;
  logic [W-1:0] QUOTIENT;
  logic [W-1:0] REMAINDER;
  logic         DIV_BY_ZERO;

  int compared   = 0;
  int mismatched = 0;

  always #5 CLK = ~CLK;

  restoring_divider #(.WIDTH(W)) dut (
    .CLK         (CLK),
    .ASYNCRESET  (ASYNCRESET),
    .I_VALID     (I_VALID),
    .I_READY     (I_READY),
    .DIVIDEND    (DIVIDEND),
    .DIVISOR     (DIVISOR),
    .O_VALID     (O_VALID),
    .O_READY     (O_READY),
    .QUOTIENT    (QUOTIENT),
    .REMAINDER   (REMAINDER),
    .DIV_BY_ZERO (DIV_BY_ZERO)
  );

  // Runs one operation from a negedge. lat = edges counted from the accepting edge (inclusive)
  // to the edge that raised O_VALID; edges = same count up to the edge that raised I_READY again.
  // After capture the operand inputs are switched to (ba, bb) with I_VALID=busy_valid.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic busy_valid,
                       input logic [W-1:0] ba, input logic [W-1:0] bb,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic z,
                       output int lat, output int edges, output bit timeout);
    int guard;
    q = '0; r = '0; z = 1'b0; lat = 0; edges = 0; timeout = 1'b0;
    guard = 0;
    while (!I_READY && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    DIVIDEND = a;
    DIVISOR  = b;
    I_VALID  = 1'b1;
    @(posedge CLK);
    edges = 1;
    @(negedge CLK);
    I_VALID  = busy_valid;
    DIVIDEND = ba;
    DIVISOR  = bb;
    guard = 0;
    while (!I_READY && guard < 40) begin
      if (O_VALID && lat == 0) begin
        lat = edges;
        q = QUOTIENT;
        r = REMAINDER;
        z = DIV_BY_ZERO;
      end
      @(posedge CLK);
      edges++;
      @(negedge CLK);
      guard++;
    end
    if (!I_READY || lat == 0) timeout = 1'b1;
    $display("op %0d/%0d -> q=%0d r=%0d dbz=%0b lat=%0d edges=%0d", a, b, q, r, z, lat, edges);
  endtask

  task automatic test_reset();
    ASYNCRESET = 1'b1;
    I_VALID    = 1'b0;
    O_READY    = 1'b1;
    DIVIDEND   = '0;
    DIVISOR    = '0;
    #3;
    compared++; if (I_READY !== 1'b1) begin mismatched++; $display("FAIL reset_i_ready: got %b want 1", I_READY); end
    compared++; if (O_VALID !== 1'b0) begin mismatched++; $display("FAIL reset_o_valid: got %b want 0", O_VALID); end
    compared++; if (QUOTIENT !== 4'd0) begin mismatched++; $display("FAIL reset_quotient: got %0d want 0", QUOTIENT); end
    compared++; if (REMAINDER !== 4'd0) begin mismatched++; $display("FAIL reset_remainder: got %0d want 0", REMAINDER); end
    compared++; if (DIV_BY_ZERO !== 1'b0) begin mismatched++; $display("FAIL reset_dbz: got %b want 0", DIV_BY_ZERO); end
    @(negedge CLK);
    @(negedge CLK);
    ASYNCRESET = 1'b0;
    $display("reset released");
  endtask

  task automatic test_basic();
    logic [W-1:0] q, r; logic z; int lat, edges; bit to;
    O_READY = 1'b1;
    do_op(4'd13, 4'd3, 1'b0, 4'd15, 4'd15, q, r, z, lat, edges, to);
    compared++; if (to !== 1'b0) begin mismatched++; $display("FAIL basic_timeout: got %b want 0", to); end
    compared++; if (lat != 5) begin mismatched++; $display("FAIL basic_latency: got %0d want 5", lat); end
    compared++; if (q !== 4'd4) begin mismatched++; $display("FAIL basic_quotient: got %0d want 4", q); end
    compared++; if (r !== 4'd1) begin mismatched++; $display("FAIL basic_remainder: got %0d want 1", r); end
    compared++; if (z !== 1'b0) begin mismatched++; $display("FAIL basic_dbz: got %b want 0", z); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] q, r; logic z; int lat, edges; bit to;
    O_READY = 1'b1;
    do_op(4'd15, 4'd1, 1'b0, 4'd0, 4'd0, q, r, z, lat, edges, to);
    compared++; if (to !== 1'b0) begin mismatched++; $display("FAIL b2b1_timeout: got %b want 0", to); end
    compared++; if (q !== 4'd15) begin mismatched++; $display("FAIL b2b1_quotient: got %0d want 15", q); end
    compared++; if (r !== 4'd0) begin mismatched++; $display("FAIL b2b1_remainder: got %0d want 0", r); end
    compared++; if (edges != 6) begin mismatched++; $display("FAIL b2b1_busy_edges: got %0d want 6", edges); end
    do_op(4'd2, 4'd7, 1'b0, 4'd9, 4'd1, q, r, z, lat, edges, to);
    compared++; if (to !== 1'b0) begin mismatched++; $display("FAIL b2b2_timeout: got %b want 0", to); end
    compared++; if (q !== 4'd0) begin mismatched++; $display("FAIL b2b2_quotient: got %0d want 0", q); end
    compared++; if (r !== 4'd2) begin mismatched++; $display("FAIL b2b2_remainder: got %0d want 2", r); end
    compared++; if (edges != 6) begin mismatched++; $display("FAIL b2b2_busy_edges: got %0d want 6", edges); end
  endtask

  task automatic test_div_zero();
    logic [W-1:0] q, r; logic z; int lat, edges; bit to;
    O_READY = 1'b1;
    do_op(4'd5, 4'd0, 1'b0, 4'd3, 4'd3, q, r, z, lat, edges, to);
    compared++; if (to !== 1'b0) begin mismatched++; $display("FAIL dz_timeout: got %b want 0", to); end
    compared++; if (q !== 4'd15) begin mismatched++; $display("FAIL dz_quotient: got %0d want 15", q); end
    compared++; if (r !== 4'd5) begin mismatched++; $display("FAIL dz_remainder: got %0d want 5", r); end
    compared++; if (z !== 1'b1) begin mismatched++; $display("FAIL dz_flag: got %b want 1", z); end
    compared++; if (lat != 5) begin mismatched++; $display("FAIL dz_latency: got %0d want 5", lat); end
  endtask

  task automatic test_backpressure();
    int guard;
    O_READY  = 1'b0;
    DIVIDEND = 4'd9;
    DIVISOR  = 4'd2;
    I_VALID  = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    I_VALID  = 1'b0;
    DIVIDEND = 4'd0;
    DIVISOR  = 4'd0;
    guard = 0;
    while (!O_VALID && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    compared++; if (O_VALID !== 1'b1) begin mismatched++; $display("FAIL bp_timeout: o_valid %b want 1", O_VALID); end
    for (int k = 0; k < 3; k++) begin
      compared++; if (QUOTIENT !== 4'd4) begin mismatched++; $display("FAIL bp_quotient[%0d]: got %0d want 4", k, QUOTIENT); end
      compared++; if (REMAINDER !== 4'd1) begin mismatched++; $display("FAIL bp_remainder[%0d]: got %0d want 1", k, REMAINDER); end
      compared++; if (DIV_BY_ZERO !== 1'b0) begin mismatched++; $display("FAIL bp_dbz[%0d]: got %b want 0", k, DIV_BY_ZERO); end
      compared++; if (I_READY !== 1'b0) begin mismatched++; $display("FAIL bp_i_ready[%0d]: got %b want 0", k, I_READY); end
      @(negedge CLK);
    end
    compared++; if (O_VALID !== 1'b1) begin mismatched++; $display("FAIL bp_held_valid: got %b want 1", O_VALID); end
    O_READY = 1'b1;
    @(posedge CLK);
    #1;
    compared++; if (I_READY !== 1'b1) begin mismatched++; $display("FAIL bp_idle_after_ready: got %b want 1", I_READY); end
    compared++; if (O_VALID !== 1'b0) begin mismatched++; $display("FAIL bp_o_valid_drop: got %b want 0", O_VALID); end
    @(negedge CLK);
    $display("op 9/2 backpressure -> q=4 r=1 held 3 cycles");
  endtask

  task automatic test_ignore_busy();
    logic [W-1:0] q, r; logic z; int lat, edges; bit to;
    O_READY = 1'b1;
    do_op(4'd12, 4'd5, 1'b1, 4'd7, 4'd7, q, r, z, lat, edges, to);
    compared++; if (to !== 1'b0) begin mismatched++; $display("FAIL ign_timeout: got %b want 0", to); end
    compared++; if (q !== 4'd2) begin mismatched++; $display("FAIL ign_quotient: got %0d want 2", q); end
    compared++; if (r !== 4'd2) begin mismatched++; $display("FAIL ign_remainder: got %0d want 2", r); end
    compared++; if (edges != 6) begin mismatched++; $display("FAIL ign_busy_edges: got %0d want 6", edges); end
    do_op(4'd7, 4'd7, 1'b0, 4'd0, 4'd0, q, r, z, lat, edges, to);
    compared++; if (to !== 1'b0) begin mismatched++; $display("FAIL ign2_timeout: got %b want 0", to); end
    compared++; if (q !== 4'd1) begin mismatched++; $display("FAIL ign2_quotient: got %0d want 1", q); end
    compared++; if (r !== 4'd0) begin mismatched++; $display("FAIL ign2_remainder: got %0d want 0", r); end
    compared++; if (lat != 5) begin mismatched++; $display("FAIL ign2_latency: got %0d want 5", lat); end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] q, r; logic z; int lat, edges; bit to;
    O_READY  = 1'b1;
    DIVIDEND = 4'd14;
    DIVISOR  = 4'd0;
    I_VALID  = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    I_VALID = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    // Two steps into 14/0: QUOTIENT=11, REMAINDER=3, DIV_BY_ZERO=1 before the pulse
    #2;
    ASYNCRESET = 1'b1;
    #1;
    compared++; if (QUOTIENT !== 4'd0) begin mismatched++; $display("FAIL ar_quotient: got %0d want 0", QUOTIENT); end
    compared++; if (REMAINDER !== 4'd0) begin mismatched++; $display("FAIL ar_remainder: got %0d want 0", REMAINDER); end
    compared++; if (DIV_BY_ZERO !== 1'b0) begin mismatched++; $display("FAIL ar_dbz: got %b want 0", DIV_BY_ZERO); end
    compared++; if (O_VALID !== 1'b0) begin mismatched++; $display("FAIL ar_o_valid: got %b want 0", O_VALID); end
    compared++; if (I_READY !== 1'b1) begin mismatched++; $display("FAIL ar_i_ready: got %b want 1", I_READY); end
    #1;
    ASYNCRESET = 1'b0;
    @(negedge CLK);
    compared++; if (O_VALID !== 1'b0) begin mismatched++; $display("FAIL ar_no_result: got %b want 0", O_VALID); end
    $display("op 14/0 aborted by reset");
    do_op(4'd10, 4'd3, 1'b0, 4'd1, 4'd1, q, r, z, lat, edges, to);
    compared++; if (to !== 1'b0) begin mismatched++; $display("FAIL ar_next_timeout: got %b want 0", to); end
    compared++; if (q !== 4'd3) begin mismatched++; $display("FAIL ar_next_quotient: got %0d want 3", q); end
    compared++; if (r !== 4'd1) begin mismatched++; $display("FAIL ar_next_remainder: got %0d want 1", r); end
    compared++; if (z !== 1'b0) begin mismatched++; $display("FAIL ar_next_dbz: got %b want 0", z); end
    compared++; if (lat != 5) begin mismatched++; $display("FAIL ar_next_latency: got %0d want 5", lat); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_backpressure();
    test_ignore_busy();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand width in bits (legal range 2..16).
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port ASYNCRESET  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port I_VALID  input  1  operand pair valid.
REQ-005 SHALL have port I_READY  output  1  block can accept operands.
REQ-006 SHALL have port DIVIDEND  input  WIDTH  unsigned dividend.
REQ-007 SHALL have port DIVISOR  input  WIDTH  unsigned divisor.
REQ-008 SHALL have port O_VALID  output  1  result valid.
REQ-009 SHALL have port O_READY  input  1  downstream accepts result.
REQ-010 SHALL have port QUOTIENT  output  WIDTH  unsigned quotient.
REQ-011 SHALL have port REMAINDER  output  WIDTH  unsigned remainder.
REQ-012 SHALL have port DIV_BY_ZERO  output  1  captured divisor was zero.

Function
REQ-013 SHALL implement an FSM with three states: IDLE, BUSY and DONE.
REQ-014 SHALL assert I_READY only in IDLE and O_VALID only in DONE, both as registered-state decodes.
REQ-015 IDLE with I_VALID=1 SHALL, on the edge, load dividend shift register, divisor and zero partial remainder, clear iteration counter, register DIV_BY_ZERO = (DIVISOR==0), and go BUSY.
REQ-016 Each BUSY edge SHALL perform one restoring step.
  - Shift {remainder, dividend} left one bit.
  - Subtract divisor from the WIDTH+1-bit shifted remainder.
  - COUT=1 (no borrow): take the difference and shift quotient bit 1 into the dividend LSB.
  - COUT=0 (borrow): keep the shifted remainder and shift in quotient bit 0.
REQ-017 BUSY SHALL last exactly WIDTH edges; the counter wraps to 0 on the last step and the FSM enters DONE on that same edge.
REQ-018 Latency SHALL be WIDTH+1 edges from the accepting edge to O_VALID=1, independent of operand values.
REQ-019 In DONE, QUOTIENT, REMAINDER and DIV_BY_ZERO SHALL be held stable until O_READY=1.
REQ-020 DONE with O_READY=1 SHALL return the FSM to IDLE on that edge; I_READY rises the following cycle, with no same-cycle re-accept.
REQ-021 I_VALID, DIVIDEND and DIVISOR SHALL be ignored outside IDLE; operands SHALL NOT be sampled after capture.
REQ-022 DIVISOR=0 SHALL yield QUOTIENT = all ones and REMAINDER = DIVIDEND, the natural algorithm result, with DIV_BY_ZERO=1.
REQ-023 Results SHALL satisfy DIVIDEND = QUOTIENT*DIVISOR + REMAINDER with REMAINDER < DIVISOR for every DIVISOR != 0.
REQ-024 QUOTIENT, REMAINDER and DIV_BY_ZERO SHALL be driven directly from registers, with no combinational path from any input.

Reset
REQ-025 ASYNCRESET=1 SHALL immediately force state IDLE and clear all datapath registers and the counter.
  - Outputs go to I_READY=1, O_VALID=0, QUOTIENT=0, REMAINDER=0, DIV_BY_ZERO=0.
REQ-026 Reset asserted mid-BUSY or in DONE SHALL discard the operation, with no result emitted.
REQ-027 After ASYNCRESET deasserts, the first rising CLK edge SHALL be able to accept operands.

Structure
REQ-028 A shared package SHALL hold the state encoding (IDLE=0, BUSY=1, DONE=2) and the default WIDTH constant.
REQ-029 The trial subtraction SHALL be one instance of sub-module sub_cout (WIDTH+1 bits, outputs O and COUT).
  - sub_cout is implemented as add-with-carry-in of the inverted subtrahend with CIN=1.
  - COUT=1 means no borrow.
REQ-030 The counter SHALL be clog2(WIDTH+1) bits wide.

Verification (WIDTH=4)
REQ-031 Accept 13/3 -> O_VALID exactly 5 edges later with QUOTIENT=4, REMAINDER=1, DIV_BY_ZERO=0.
REQ-032 Run 15/1 -> 15,0 and 2/7 -> 0,2, back-to-back, with O_READY=1 throughout -> I_READY low exactly 6 cycles per op.
REQ-033 Run 5/0 -> QUOTIENT=15, REMAINDER=5, DIV_BY_ZERO=1.
REQ-034 Backpressure: 9/2 with O_READY low 3 cycles in DONE -> 4,1 held stable; FSM reaches IDLE on the O_READY edge.
REQ-035 Drive I_VALID=1 with 7/7 while BUSY on 12/5 -> result 2,2 unaffected; 7/7 taken only after the return to IDLE -> 1,0.
REQ-036 Pulse ASYNCRESET between edges during BUSY step 2 -> outputs zero immediately with no O_VALID; next op 10/3 -> 3,1.
